// File: rtl/cart_loader.sv
// cart_loader: streams a ColecoVision ROM image from the ioctl download port
// into cart RAM, measures the image, validates the header and derives the
// power-of-two mirror mask applied to the console's cartridge address bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no cartridge loaded since reset
// S_LOAD  | download in progress, bytes forwarded to cart RAM
// S_FINISH| widening the mirror mask until it covers the image size
// S_READY | cartridge resident, mask/size/valid held
module cart_loader #(
  parameter int ADDR_W = 15,
  parameter int INDEX  = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              cart_we,
  output logic [ADDR_W-1:0] cart_wa,
  output logic [7:0]        cart_wd,
  input  logic [ADDR_W-1:0] cart_a_i,
  output logic [ADDR_W-1:0] cart_a_o,
  output logic [ADDR_W:0]   cart_size,
  output logic [ADDR_W-1:0] cart_mask,
  output logic              cart_busy,
  output logic              cart_valid,
  output logic              cart_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH, S_READY} state_t;

  localparam logic [5:0]        IDX  = 6'(INDEX);
  localparam logic [ADDR_W-1:0] ONES = '1;
  localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   TWO  = (ADDR_W+1)'(2);

  state_t              state_q, state_d;
  logic                dl_q;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [7:0]          wd_q, wd_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     size_q, size_d;
  logic [ADDR_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   m_q, m_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [7:0]          hdr0_q, hdr0_d;
  logic [7:0]          hdr1_q, hdr1_d;

  logic                start;
  logic                fall;
  logic                in_range;
  logic [ADDR_W:0]     addr_p1;
  logic [ADDR_W:0]     m_p1;
  logic                hdr_ok;
  logic                unused_idx;

  assign unused_idx = ^ioctl_index[7:6];

  assign start    = ioctl_download & ~dl_q & (ioctl_index[5:0] == IDX);
  assign fall     = ~ioctl_download & dl_q;
  assign in_range = (ioctl_addr[24:ADDR_W] == '0);
  assign addr_p1  = {1'b0, ioctl_addr[ADDR_W-1:0]} + ONE;
  assign m_p1     = {1'b0, m_q} + ONE;
  assign hdr_ok   = ((hdr0_q == 8'hAA) && (hdr1_q == 8'h55)) ||
                    ((hdr0_q == 8'h55) && (hdr1_q == 8'hAA));

  // Next-state and datapath updates; a start from any non-LOAD state wins.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    count_d = count_q;
    size_d  = size_q;
    mask_d  = mask_q;
    m_d     = m_q;
    valid_d = valid_q;
    err_d   = err_q;
    hdr0_d  = hdr0_q;
    hdr1_d  = hdr1_q;

    case (state_q)
      S_LOAD: begin
        if (ioctl_wr) begin
          if (in_range) begin
            we_d = 1'b1;
            wa_d = ioctl_addr[ADDR_W-1:0];
            wd_d = ioctl_dout;
            if (addr_p1 > count_q) count_d = addr_p1;
            if (ioctl_addr[ADDR_W-1:0] == '0) hdr0_d = ioctl_dout;
            if (ioctl_addr[ADDR_W-1:0] == ONES'(1)) hdr1_d = ioctl_dout;
          end else begin
            err_d = 1'b1;
          end
        end
        // A byte arriving with the fall is already folded into count_d.
        if (fall) begin
          size_d  = count_d;
          m_d     = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (m_p1 < size_q) begin
          m_d = {m_q[ADDR_W-2:0], 1'b1};
        end else begin
          mask_d  = m_q;
          valid_d = (size_q >= TWO) && hdr_ok;
          state_d = S_READY;
        end
      end
      default: ;
    endcase

    if (start && (state_q != S_LOAD)) begin
      state_d = S_LOAD;
      count_d = '0;
      err_d   = 1'b0;
      valid_d = 1'b0;
      hdr0_d  = '0;
      hdr1_d  = '0;
      mask_d  = ONES;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers. dl_q resets high so a download still active when
  // reset releases is not mistaken for a fresh start.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q    <= 1'b1;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      count_q <= '0;
      size_q  <= '0;
      mask_q  <= ONES;
      m_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hdr0_q  <= '0;
      hdr1_q  <= '0;
    end else begin
      dl_q    <= ioctl_download;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      size_q  <= size_d;
      mask_q  <= mask_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hdr0_q  <= hdr0_d;
      hdr1_q  <= hdr1_d;
    end
  end

  assign cart_we    = we_q;
  assign cart_wa    = wa_q;
  assign cart_wd    = wd_q;
  assign cart_size  = size_q;
  assign cart_mask  = mask_q;
  assign cart_valid = valid_q;
  assign cart_err   = err_q;
  assign cart_busy  = (state_q == S_LOAD) || (state_q == S_FINISH);
  assign cart_a_o   = cart_a_i & mask_q;

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: scoreboard of expected cart RAM writes plus
// post-load checks of size, mask, valid, err and address mirroring.
module tb_cart_loader;
  localparam int AW = 15;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic          cart_we;
  logic [AW-1:0] cart_wa;
  logic [7:0]    cart_wd;
  logic [AW-1:0] cart_a_i = '0;
  logic [AW-1:0] cart_a_o;
  logic [AW:0]   cart_size;
  logic [AW-1:0] cart_mask;
  logic          cart_busy;
  logic          cart_valid;
  logic          cart_err;

  cart_loader #(.ADDR_W(AW), .INDEX(1)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cart_we(cart_we), .cart_wa(cart_wa), .cart_wd(cart_wd),
    .cart_a_i(cart_a_i), .cart_a_o(cart_a_o), .cart_size(cart_size),
    .cart_mask(cart_mask), .cart_busy(cart_busy), .cart_valid(cart_valid),
    .cart_err(cart_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_we = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // Cycle counter used to verify one-clock write latency.
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Write monitor: every cart_we must match the oldest expected write.
  always @(negedge clk_sys) begin
    if (cart_we) begin
      n_we <= n_we + 1;
      if (q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("we_wa", 32'(cart_wa), 32'(e.a));
        check("we_wd", 32'(cart_wd), 32'(e.d));
        check("we_latency", cyc, e.c);
      end
    end
  end

  task automatic dl(input logic [7:0] idx, input int n, input logic [7:0] b0,
                    input logic [7:0] b1, input bit fall_last, input string nm);
    int base;
    int c;
    int exp_n;
    tick;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    base = n_we;
    tick;
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = (i == 0) ? b0 : (i == 1) ? b1 : (8'(i) ^ 8'h5A);
      if (fall_last && i == n - 1) ioctl_download = 1'b0;
      if (idx[5:0] == 6'd1 && i < 32768)
        q.push_back('{a: AW'(i), d: ioctl_dout, c: cyc + 1});
      tick;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    c = 0;
    while (cart_busy && c < 30) begin
      tick;
      c++;
    end
    check({nm, "_busy_fall"}, 32'(c <= 17), 32'd1);
    repeat (3) tick;
    exp_n = (idx[5:0] != 6'd1) ? 0 : (n > 32768) ? 32768 : n;
    check({nm, "_nwe"}, n_we - base, exp_n);
    check({nm, "_queue_empty"}, q.size(), 0);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_we", 32'(cart_we), 0);
    check("rst_busy", 32'(cart_busy), 0);
    check("rst_valid", 32'(cart_valid), 0);
    check("rst_err", 32'(cart_err), 0);
    check("rst_size", 32'(cart_size), 0);
    check("rst_mask", 32'(cart_mask), 32'h7FFF);
    check("rst_wa", 32'(cart_wa), 0);
    check("rst_wd", 32'(cart_wd), 0);
    reset = 1'b0;
    tick;

    dl(8'd1, 8192, 8'hAA, 8'h55, 1'b0, "t1");
    check("t1_size", 32'(cart_size), 8192);
    check("t1_mask", 32'(cart_mask), 32'h1FFF);
    check("t1_valid", 32'(cart_valid), 1);
    check("t1_err", 32'(cart_err), 0);
    check("t1_busy", 32'(cart_busy), 0);
    cart_a_i = 15'h2005;
    #1;
    check("t1_mirror", 32'(cart_a_o), 32'h0005);

    dl(8'd1, 12288, 8'h55, 8'hAA, 1'b1, "t2");
    check("t2_size", 32'(cart_size), 12288);
    check("t2_mask", 32'(cart_mask), 32'h3FFF);
    check("t2_valid", 32'(cart_valid), 1);
    cart_a_i = 15'h7123;
    #1;
    check("t2_mirror", 32'(cart_a_o), 32'h3123);

    dl(8'd1, 32770, 8'hAA, 8'h55, 1'b0, "t3");
    check("t3_err", 32'(cart_err), 1);
    check("t3_size", 32'(cart_size), 32768);
    check("t3_mask", 32'(cart_mask), 32'h7FFF);
    check("t3_valid", 32'(cart_valid), 1);

    dl(8'd1, 4096, 8'h00, 8'h00, 1'b0, "t4");
    check("t4_valid", 32'(cart_valid), 0);
    check("t4_mask", 32'(cart_mask), 32'h0FFF);
    check("t4_err", 32'(cart_err), 0);

    dl(8'd0, 100, 8'hAA, 8'h55, 1'b0, "t5");
    check("t5_size", 32'(cart_size), 4096);
    check("t5_mask", 32'(cart_mask), 32'h0FFF);
    check("t5_valid", 32'(cart_valid), 0);

    dl(8'd1, 1, 8'hAA, 8'h00, 1'b0, "t6");
    check("t6_size", 32'(cart_size), 1);
    check("t6_mask", 32'(cart_mask), 0);
    check("t6_valid", 32'(cart_valid), 0);

    dl(8'd1, 0, 8'hAA, 8'h55, 1'b0, "t7");
    check("t7_size", 32'(cart_size), 0);
    check("t7_mask", 32'(cart_mask), 0);
    check("t7_valid", 32'(cart_valid), 0);

    dl(8'd1, 2, 8'hAA, 8'h55, 1'b0, "t8");
    check("t8_size", 32'(cart_size), 2);
    check("t8_mask", 32'(cart_mask), 1);
    check("t8_valid", 32'(cart_valid), 1);

    // Reset in the middle of a load.
    tick;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 500; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i) ^ 8'h5A;
      q.push_back('{a: AW'(i), d: ioctl_dout, c: cyc + 1});
      tick;
    end
    reset = 1'b1;
    ioctl_addr = 25'd500;
    #1;
    check("rst_mid_we", 32'(cart_we), 0);
    check("rst_mid_busy", 32'(cart_busy), 0);
    check("rst_mid_mask", 32'(cart_mask), 32'h7FFF);
    check("rst_mid_size", 32'(cart_size), 0);
    check("rst_mid_pending", q.size(), 1);
    q.delete();
    repeat (2) tick;
    reset = 1'b0;
    base = n_we;
    for (int i = 501; i < 521; i++) begin
      ioctl_addr = 25'(i);
      tick;
    end
    ioctl_wr = 1'b0;
    repeat (3) tick;
    check("rst_after_nwe", n_we - base, 0);
    check("rst_after_busy", 32'(cart_busy), 0);
    ioctl_download = 1'b0;
    tick;

    dl(8'd1, 2, 8'h55, 8'hAA, 1'b0, "t9");
    check("t9_valid", 32'(cart_valid), 1);
    check("t9_mask", 32'(cart_mask), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
